pipe_rd_responder: RTL and testbench

//  Responder terminating the left end of the fthread pipeline read chain (pipe index 0).

---
 rtl/pipe_rd_responder_pkg.sv | 14 +
 rtl/pipe_rd_responder_if.sv | 29 ++
 rtl/pipe_rd_responder_tag_fifo.sv | 42 ++++
 rtl/pipe_rd_responder.sv | 79 +++++++
 tb/tb_pipe_rd_responder.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_rd_responder_pkg.sv
// Shared pipe read-chain constants and request/response record types.
package pipe_rd_responder_pkg;
    localparam int IF_TAG          = 6;
    localparam int PIPE_DATA_WIDTH = 512;

    typedef struct packed {
        logic [IF_TAG-1:0] tag;
    } pipe_rd_req_t;

    typedef struct packed {
        logic [IF_TAG-1:0]          tag;
        logic [PIPE_DATA_WIDTH-1:0] data;
    } pipe_rd_rsp_t;
endpackage

// File: rtl/pipe_rd_responder_if.sv
// Pipe read request/response and producer-stream handshake bundle.
interface pipe_rd_responder_if
    import pipe_rd_responder_pkg::*;
#(
    parameter int TAG_WIDTH  = IF_TAG,
    parameter int DATA_WIDTH = PIPE_DATA_WIDTH
);
    logic                  pipe_tx_rd_valid;
    logic [TAG_WIDTH-1:0]  pipe_tx_rd_tag;
    logic                  pipe_tx_rd_ready;
    logic                  pipe_rx_rd_valid;
    logic [TAG_WIDTH-1:0]  pipe_rx_rd_tag;
    logic [DATA_WIDTH-1:0] pipe_rx_data;
    logic                  pipe_rx_rd_ready;
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_ready;

    // Requester/producer side (fthread left pipe plus line source).
    modport master (
        output pipe_tx_rd_valid, pipe_tx_rd_tag, pipe_rx_rd_ready, src_valid, src_data,
        input  pipe_tx_rd_ready, pipe_rx_rd_valid, pipe_rx_rd_tag, pipe_rx_data, src_ready
    );

    modport slave (
        input  pipe_tx_rd_valid, pipe_tx_rd_tag, pipe_rx_rd_ready, src_valid, src_data,
        output pipe_tx_rd_ready, pipe_rx_rd_valid, pipe_rx_rd_tag, pipe_rx_data, src_ready
    );
endinterface

// File: rtl/pipe_rd_responder_tag_fifo.sv
// Synchronous FIFO with wrap-bit pointers; count, full and empty come from registered pointers only.
module pipe_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 6,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/pipe_rd_responder.sv
// Terminates pipe index 0: pairs each queued read tag, in order, with the next producer line.
module pipe_rd_responder
    import pipe_rd_responder_pkg::*;
#(
    parameter int TAG_WIDTH      = IF_TAG,
    parameter int DATA_WIDTH     = PIPE_DATA_WIDTH,
    parameter int TAG_FIFO_DEPTH = 16,
    localparam int CW            = $clog2(TAG_FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_rd_responder_if.slave   bus,
    output logic [CW-1:0]        outstanding,
    output logic [31:0]          req_count,
    output logic [31:0]          rsp_count
);
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [TAG_WIDTH-1:0]  head_tag;
    logic                  push;
    logic                  fire;
    logic                  rsp_done;

    logic                  vld_p1;
    logic [TAG_WIDTH-1:0]  tag_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    assign bus.pipe_tx_rd_ready = !rst && !fifo_full;
    assign push                 = bus.pipe_tx_rd_valid && bus.pipe_tx_rd_ready;

    pipe_tag_fifo #(
        .DEPTH (TAG_FIFO_DEPTH),
        .WIDTH (TAG_WIDTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (bus.pipe_tx_rd_tag),
        .pop   (fire),
        .rdata (head_tag),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding)
    );

    // A line is consumed only when a tag is waiting and the output slot is free or draining.
    assign fire          = !rst && !fifo_empty && bus.src_valid && (!vld_p1 || bus.pipe_rx_rd_ready);
    assign bus.src_ready = fire;
    assign rsp_done      = vld_p1 && bus.pipe_rx_rd_ready;

    // Stage p1: response register, held while the fthread stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            tag_p1  <= '0;
            data_p1 <= '0;
        end else if (fire) begin
            vld_p1  <= 1'b1;
            tag_p1  <= head_tag;
            data_p1 <= bus.src_data;
        end else if (bus.pipe_rx_rd_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_count <= '0;
            rsp_count <= '0;
        end else begin
            if (push)     req_count <= req_count + 32'd1;
            if (rsp_done) rsp_count <= rsp_count + 32'd1;
        end
    end

    assign bus.pipe_rx_rd_valid = vld_p1;
    assign bus.pipe_rx_rd_tag   = tag_p1;
    assign bus.pipe_rx_data     = data_p1;
endmodule

// File: tb/tb_pipe_rd_responder.sv
// Bench for pipe_rd_responder: vector table, directed corner sequences and a queue-based scoreboard.
module tb_pipe_rd_responder;
    import pipe_rd_responder_pkg::*;

    localparam int TW    = 6;
    localparam int DW    = 512;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_rd_responder_if #(.TAG_WIDTH(TW), .DATA_WIDTH(DW)) bus();
    logic [CW-1:0] outstanding;
    logic [31:0]   req_count;
    logic [31:0]   rsp_count;

    pipe_rd_responder #(
        .TAG_WIDTH      (TW),
        .DATA_WIDTH     (DW),
        .TAG_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .outstanding (outstanding),
        .req_count   (req_count),
        .rsp_count   (rsp_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] line(input int unsigned i);
        logic [DW-1:0] r;
        for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = (i * 32'h9E3779B9) + k;
        return r;
    endfunction

    // Scoreboard: tags accepted but unpaired, and paired responses awaiting delivery.
    logic [TW-1:0]  tq[$];
    pipe_rd_rsp_t   pq[$];
    int unsigned    m_req = 0;
    int unsigned    m_rsp = 0;
    bit             mon_en = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            int n;
            logic exp_fire;
            pipe_rd_rsp_t p;
            n = tq.size();
            if (rst) begin
                chk("rst_tx_ready", bus.pipe_tx_rd_ready, '0);
                chk("rst_src_ready", bus.src_ready, '0);
                tq.delete();
                pq.delete();
                m_req = 0;
                m_rsp = 0;
            end else begin
                exp_fire = (n > 0) && bus.src_valid && ((pq.size() == 0) || bus.pipe_rx_rd_ready);
                chk("sb_tx_ready", bus.pipe_tx_rd_ready, (n < DEPTH));
                chk("sb_outstanding", outstanding, n);
                chk("sb_rx_valid", bus.pipe_rx_rd_valid, (pq.size() != 0));
                chk("sb_req_count", req_count, m_req);
                chk("sb_rsp_count", rsp_count, m_rsp);
                chk("sb_src_ready", bus.src_ready, exp_fire);
                if (pq.size() != 0) begin
                    chk("sb_rx_tag", bus.pipe_rx_rd_tag, pq[0].tag);
                    chk("sb_rx_data", bus.pipe_rx_data, pq[0].data);
                    if (bus.pipe_rx_rd_ready) begin
                        void'(pq.pop_front());
                        m_rsp++;
                    end
                end
                if (exp_fire) begin
                    p.tag  = tq.pop_front();
                    p.data = bus.src_data;
                    pq.push_back(p);
                end
                if (bus.pipe_tx_rd_valid && (n < DEPTH)) begin
                    tq.push_back(bus.pipe_tx_rd_tag);
                    m_req++;
                end
            end
        end
    end

    bit          auto_tag = 0;
    bit          auto_src = 0;
    int unsigned tag_ctr  = 0;
    int unsigned src_idx  = 0;

    // Advance one clock; in auto mode present the next tag / line after each accepted handshake.
    task automatic step();
        logic txh, srh;
        #1;
        txh = bus.pipe_tx_rd_valid && bus.pipe_tx_rd_ready;
        srh = bus.src_valid && bus.src_ready;
        @(posedge clk);
        #1;
        if (auto_tag && txh) begin
            tag_ctr++;
            bus.pipe_tx_rd_tag = tag_ctr[TW-1:0];
        end
        if (auto_src && srh) begin
            src_idx++;
            bus.src_data = line(src_idx);
        end
    endtask

    task automatic drain(input string name);
        int c;
        bus.pipe_tx_rd_valid = 1'b0;
        bus.src_valid        = 1'b1;
        bus.pipe_rx_rd_ready = 1'b1;
        c = 0;
        while ((tq.size() + pq.size()) != 0 && c < 100) begin
            step();
            c++;
        end
        chk(name, tq.size() + pq.size(), 0);
    endtask

    typedef struct {
        logic          rst, txv;
        logic [TW-1:0] tag;
        logic          srcv;
        logic [7:0]    sb;
        logic          rxr;
        logic          e_txr, e_srcr, e_rxv, chk_td;
        logic [TW-1:0] e_tag;
        logic [7:0]    e_b;
        logic [CW-1:0] e_out;
        logic [31:0]   e_req, e_rsp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int got_n, bub, seen, c;
        logic [TW-1:0]  got[$];
        logic [TW-1:0]  h_tag;
        logic [DW-1:0]  h_data;
        logic [DW-1:0]  exp_data;

        // rst, txv, tag, srcv, sb, rxr | e_txr, e_srcr, e_rxv, chk_td, e_tag, e_b, e_out, e_req, e_rsp
        tbl[0] = '{1'b1, 1'b0, 6'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 8'h00, 5'd0, 32'd0, 32'd0};
        tbl[1] = '{1'b1, 1'b0, 6'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 8'h00, 5'd0, 32'd0, 32'd0};
        tbl[2] = '{1'b0, 1'b0, 6'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 8'h00, 5'd0, 32'd0, 32'd0};
        tbl[3] = '{1'b0, 1'b1, 6'h05, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 8'h00, 5'd0, 32'd0, 32'd0};
        tbl[4] = '{1'b0, 1'b0, 6'h05, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'h00, 8'h00, 5'd1, 32'd1, 32'd0};
        tbl[5] = '{1'b0, 1'b0, 6'h05, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'h05, 8'hA5, 5'd0, 32'd1, 32'd0};
        tbl[6] = '{1'b0, 1'b0, 6'h05, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h05, 8'hA5, 5'd0, 32'd1, 32'd1};

        bus.pipe_tx_rd_valid = 1'b0;
        bus.pipe_tx_rd_tag   = '0;
        bus.pipe_rx_rd_ready = 1'b0;
        bus.src_valid        = 1'b0;
        bus.src_data         = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mon_en = 1;

        // Reset and single-request latency vectors.
        for (int i = 0; i < 7; i++) begin
            rst                  = tbl[i].rst;
            bus.pipe_tx_rd_valid = tbl[i].txv;
            bus.pipe_tx_rd_tag   = tbl[i].tag;
            bus.src_valid        = tbl[i].srcv;
            bus.src_data         = {64{tbl[i].sb}};
            bus.pipe_rx_rd_ready = tbl[i].rxr;
            #1;
            chk($sformatf("v%0d_tx_ready", i), bus.pipe_tx_rd_ready, tbl[i].e_txr);
            chk($sformatf("v%0d_src_ready", i), bus.src_ready, tbl[i].e_srcr);
            chk($sformatf("v%0d_rx_valid", i), bus.pipe_rx_rd_valid, tbl[i].e_rxv);
            chk($sformatf("v%0d_outstanding", i), outstanding, tbl[i].e_out);
            chk($sformatf("v%0d_req_count", i), req_count, tbl[i].e_req);
            chk($sformatf("v%0d_rsp_count", i), rsp_count, tbl[i].e_rsp);
            if (tbl[i].chk_td) begin
                chk($sformatf("v%0d_rx_tag", i), bus.pipe_rx_rd_tag, tbl[i].e_tag);
                chk($sformatf("v%0d_rx_data", i), bus.pipe_rx_data, {64{tbl[i].e_b}});
            end
            step();
        end

        // Fill to capacity with no source, then release and expect tags 0..16 in order.
        auto_tag = 1; auto_src = 1;
        tag_ctr = 0; src_idx = 100;
        bus.src_data = line(src_idx);
        bus.pipe_tx_rd_tag = '0;
        bus.pipe_tx_rd_valid = 1'b1;
        bus.src_valid = 1'b0;
        bus.pipe_rx_rd_ready = 1'b1;
        c = 0;
        while (tag_ctr < 16 && c < 40) begin step(); c++; end
        chk("fill_accepted", tag_ctr, 16);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fill_tx_ready_low", bus.pipe_tx_rd_ready, 1'b0);
            chk("fill_outstanding", outstanding, 16);
            step();
        end
        bus.src_valid = 1'b1;
        c = 0;
        while (got.size() < 17 && c < 60) begin
            #1;
            if (bus.pipe_rx_rd_valid && bus.pipe_rx_rd_ready) got.push_back(bus.pipe_rx_rd_tag);
            if (tag_ctr >= 17) bus.pipe_tx_rd_valid = 1'b0;
            step();
            c++;
        end
        chk("fill_rsp_count", got.size(), 17);
        for (int k = 0; k < got.size(); k++) chk($sformatf("fill_order_%0d", k), got[k], k);
        drain("fill_drain");

        // Backpressure: response held for 5 stalled cycles, then one beat per cycle.
        bus.pipe_rx_rd_ready = 1'b0;
        bus.pipe_tx_rd_valid = 1'b1;
        repeat (4) step();
        bus.pipe_tx_rd_valid = 1'b0;
        c = 0;
        while (!bus.pipe_rx_rd_valid && c < 10) begin step(); c++; end
        chk("bp_rx_valid_seen", bus.pipe_rx_rd_valid, 1'b1);
        h_tag  = bus.pipe_rx_rd_tag;
        h_data = bus.pipe_rx_data;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_valid", bus.pipe_rx_rd_valid, 1'b1);
            chk("bp_hold_tag", bus.pipe_rx_rd_tag, h_tag);
            chk("bp_hold_data", bus.pipe_rx_data, h_data);
            chk("bp_src_ready_low", bus.src_ready, 1'b0);
            step();
        end
        bus.pipe_rx_rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("bp_beat_%0d", i), bus.pipe_rx_rd_valid, 1'b1);
            step();
        end
        drain("bp_drain");

        // Streaming: 1000 lines, no bubbles once the pipe is primed.
        bus.pipe_tx_rd_valid = 1'b1;
        bus.src_valid = 1'b1;
        bus.pipe_rx_rd_ready = 1'b1;
        got_n = 0; bub = 0; seen = 0;
        for (int i = 0; i < 1200 && got_n < 1000; i++) begin
            if (bus.pipe_rx_rd_valid) begin
                seen = 1;
                got_n++;
            end else if (seen != 0) begin
                bub++;
            end
            step();
        end
        chk("stream_lines", got_n, 1000);
        chk("stream_bubbles", bub, 0);
        #1;
        chk("stream_invariant", req_count - rsp_count, 32'(outstanding) + 32'(bus.pipe_rx_rd_valid));
        drain("stream_drain");

        // Mid-operation reset with 7 queued tags and a held response.
        bus.pipe_rx_rd_ready = 1'b0;
        bus.src_valid = 1'b0;
        bus.pipe_tx_rd_valid = 1'b1;
        c = 0;
        while (outstanding < 8 && c < 20) begin step(); c++; end
        bus.pipe_tx_rd_valid = 1'b0;
        bus.src_valid = 1'b1;
        step();
        bus.src_valid = 1'b0;
        #1;
        chk("mid_pre_outstanding", outstanding, 7);
        chk("mid_pre_rx_valid", bus.pipe_rx_rd_valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mid_rx_valid", bus.pipe_rx_rd_valid, 1'b0);
        chk("mid_outstanding", outstanding, 0);
        chk("mid_req_count", req_count, 0);
        chk("mid_rsp_count", rsp_count, 0);
        chk("mid_rx_tag", bus.pipe_rx_rd_tag, 0);
        chk("mid_rx_data", bus.pipe_rx_data, 0);
        chk("mid_tx_ready", bus.pipe_tx_rd_ready, 1'b1);
        auto_tag = 0;
        bus.pipe_tx_rd_tag = 6'h3F;
        bus.pipe_tx_rd_valid = 1'b1;
        step();
        bus.pipe_tx_rd_valid = 1'b0;
        exp_data = bus.src_data;
        bus.src_valid = 1'b1;
        bus.pipe_rx_rd_ready = 1'b1;
        c = 0;
        while (!bus.pipe_rx_rd_valid && c < 10) begin step(); c++; end
        chk("mid_new_valid", bus.pipe_rx_rd_valid, 1'b1);
        chk("mid_new_tag", bus.pipe_rx_rd_tag, 6'h3F);
        chk("mid_new_data", bus.pipe_rx_data, exp_data);
        drain("mid_drain");

        // Randomized traffic under three load profiles.
        auto_tag = 1;
        bus.pipe_tx_rd_tag = tag_ctr[TW-1:0];
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 1000; i++) begin
                case (ph)
                    0: begin
                        bus.pipe_tx_rd_valid = ($urandom_range(0, 99) < 70);
                        bus.src_valid        = ($urandom_range(0, 99) < 70);
                        bus.pipe_rx_rd_ready = ($urandom_range(0, 99) < 70);
                    end
                    1: begin
                        bus.pipe_tx_rd_valid = ($urandom_range(0, 99) < 90);
                        bus.src_valid        = ($urandom_range(0, 99) < 25);
                        bus.pipe_rx_rd_ready = ($urandom_range(0, 99) < 50);
                    end
                    default: begin
                        bus.pipe_tx_rd_valid = ($urandom_range(0, 99) < 30);
                        bus.src_valid        = ($urandom_range(0, 99) < 90);
                        bus.pipe_rx_rd_ready = ($urandom_range(0, 99) < 90);
                    end
                endcase
                step();
            end
        end
        drain("rand_drain");
        #1;
        chk("final_outstanding", outstanding, 0);
        chk("final_counts", req_count - rsp_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
